// File: rtl/ula_core.sv
// ula_core: responder end of the ULA stimulus interface.
// Holds a small register bank and runs A op REG[reg_sel]. ADD, SUB and AND
// finish in one cycle. MUL is an iterative shift-add that keeps busy high
// for DATA_W cycles.
module ula_core #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 4
) (
    input  logic                     clk_ula,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        A,
    input  logic [$clog2(NREGS)-1:0] reg_sel,
    input  logic [1:0]               instru,
    input  logic                     valid_ula,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [$clog2(NREGS)-1:0] addr,
    input  logic                     valid_reg,
    output logic [DATA_W-1:0]        C,
    output logic                     carry,
    output logic                     valid_out,
    output logic                     busy,
    output logic                     drop
);

    localparam int SEL_W = $clog2(NREGS);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // Register bank. Each entry lives in its own generate scope so that
    // every write port has exactly one driver.
    logic [DATA_W-1:0] regs_q [NREGS];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] r_q;

            // Register write. Writes are accepted in every state, including busy.
            always_ff @(posedge clk_ula) begin
                if (rst) begin
                    r_q <= '0;
                end else if (valid_reg && (addr == SEL_W'(gi))) begin
                    r_q <= data_in;
                end
            end

            assign regs_q[gi] = r_q;
        end
    endgenerate

    // The operand is read before this edge's write takes effect, so a
    // same-edge write to the same index is not bypassed.
    logic [DATA_W-1:0] operand_b;
    assign operand_b = regs_q[reg_sel];

    state_t              state_q, state_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplr_q,  mplr_d;
    logic [2*DATA_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [DATA_W-1:0]   c_q,     c_d;
    logic                carry_q, carry_d;
    logic                valid_q, valid_d;
    logic                drop_q,  drop_d;

    logic [DATA_W:0]     add_sum;
    logic [2*DATA_W-1:0] step_acc;

    assign add_sum  = {1'b0, A} + {1'b0, operand_b};
    assign step_acc = acc_q + (mplr_q[0] ? mcand_q : '0);

    // Next-state and result logic. In MUL, the final step's sum feeds the
    // result directly, so completion lands on the DATA_W-th edge.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        carry_d = carry_q;
        valid_d = 1'b0;
        drop_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_ula) begin
                    case (instru)
                        OP_ADD: begin
                            c_d     = add_sum[DATA_W-1:0];
                            carry_d = add_sum[DATA_W];
                            valid_d = 1'b1;
                        end
                        OP_SUB: begin
                            c_d     = A - operand_b;
                            carry_d = (A < operand_b);
                            valid_d = 1'b1;
                        end
                        OP_AND: begin
                            c_d     = A & operand_b;
                            carry_d = 1'b0;
                            valid_d = 1'b1;
                        end
                        default: begin
                            mcand_d = {{DATA_W{1'b0}}, A};
                            mplr_d  = operand_b;
                            acc_d   = '0;
                            cnt_d   = CNT_W'(DATA_W);
                            state_d = S_MUL;
                        end
                    endcase
                end
            end
            default: begin
                if (valid_ula) begin
                    drop_d = 1'b1;
                end
                acc_d   = step_acc;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    c_d     = step_acc[DATA_W-1:0];
                    carry_d = |step_acc[2*DATA_W-1:DATA_W];
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and output registers. Reset aborts any multiply in flight.
    always_ff @(posedge clk_ula) begin
        if (rst) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign C         = c_q;
    assign carry     = carry_q;
    assign valid_out = valid_q;
    assign busy      = (state_q == S_MUL);
    assign drop      = drop_q;

endmodule

// File: tb/tb_ula_core.sv
// Scoreboard bench for ula_core. The stimulus side pushes expected results
// computed from plain arithmetic. The monitor pops and compares them whenever
// valid_out is seen, and it checks busy and drop in every cycle.
module tb_ula_core;

    logic        clk_ula = 1'b0;
    logic        rst;
    logic [15:0] A;
    logic [1:0]  reg_sel;
    logic [1:0]  instru;
    logic        valid_ula;
    logic [15:0] data_in;
    logic [1:0]  addr;
    logic        valid_reg;
    logic [15:0] C;
    logic        carry;
    logic        valid_out;
    logic        busy;
    logic        drop;

    ula_core #(.DATA_W(16), .NREGS(4)) dut (
        .clk_ula   (clk_ula),
        .rst       (rst),
        .A         (A),
        .reg_sel   (reg_sel),
        .instru    (instru),
        .valid_ula (valid_ula),
        .data_in   (data_in),
        .addr      (addr),
        .valid_reg (valid_reg),
        .C         (C),
        .carry     (carry),
        .valid_out (valid_out),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk_ula = ~clk_ula;

    typedef struct {
        logic [15:0] c;
        logic        cy;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] m_regs [4];
    int          m_busy;
    logic        m_drop_now;
    logic [15:0] m_mul_c;
    logic        m_mul_cy;
    bit          mon_en;
    int          checks;
    int          passes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock cycle of stimulus. The model is updated at the edge using
    // the register contents from before this edge's write.
    task automatic cycle(input bit vu, input logic [1:0] op, input logic [15:0] a,
                         input logic [1:0] rs, input bit vr, input logic [1:0] ad,
                         input logic [15:0] d);
        logic        was_busy;
        logic [15:0] b;
        logic [16:0] s;
        logic [31:0] p;
        valid_ula = vu;
        instru    = op;
        A         = a;
        reg_sel   = rs;
        valid_reg = vr;
        addr      = ad;
        data_in   = d;
        @(posedge clk_ula);
        was_busy   = (m_busy > 0);
        m_drop_now = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) exp_q.push_back('{m_mul_c, m_mul_cy});
        end
        if (vu) begin
            if (was_busy) begin
                m_drop_now = 1'b1;
            end else begin
                b = m_regs[rs];
                case (op)
                    2'd0: begin
                        s = {1'b0, a} + {1'b0, b};
                        exp_q.push_back('{s[15:0], s[16]});
                    end
                    2'd1: exp_q.push_back('{a - b, (a < b)});
                    2'd2: exp_q.push_back('{a & b, 1'b0});
                    default: begin
                        p        = {16'd0, a} * {16'd0, b};
                        m_mul_c  = p[15:0];
                        m_mul_cy = (p[31:16] != 16'd0);
                        m_busy   = 16;
                    end
                endcase
            end
        end
        if (vr) m_regs[ad] = d;
        #1;
        valid_ula = 1'b0;
        valid_reg = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 16'd0, 2'd0, 1'b0, 2'd0, 16'd0);
    endtask

    task automatic wr(input logic [1:0] ad, input logic [15:0] d);
        cycle(1'b0, 2'd0, 16'd0, 2'd0, 1'b1, ad, d);
    endtask

    task automatic op(input logic [1:0] o, input logic [15:0] a, input logic [1:0] rs);
        cycle(1'b1, o, a, rs, 1'b0, 2'd0, 16'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        valid_ula = 1'b0;
        valid_reg = 1'b0;
        @(posedge clk_ula);
        for (int i = 0; i < 4; i++) m_regs[i] = 16'd0;
        m_busy     = 0;
        m_drop_now = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    // Monitor: one line per completed transaction, with per-cycle checks of busy and drop.
    always @(negedge clk_ula) begin
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(m_busy > 0));
            chk("drop", 32'(drop), 32'(m_drop_now));
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("valid_out_unexpected", 32'(valid_out), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("txn C=%h carry=%0d (expect %h/%0d)", C, carry, mon_e.c, mon_e.cy);
                    chk("C", 32'(C), 32'(mon_e.c));
                    chk("carry", 32'(carry), 32'(mon_e.cy));
                end
            end else if (exp_q.size() != 0) begin
                chk("valid_out_missing", 32'(valid_out), 32'd1);
                mon_e = exp_q.pop_front();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks     = 0;
        passes     = 0;
        mon_en     = 1'b0;
        m_busy     = 0;
        m_drop_now = 1'b0;
        rst        = 1'b1;
        A          = 16'd0;
        reg_sel    = 2'd0;
        instru     = 2'd0;
        valid_ula  = 1'b0;
        data_in    = 16'd0;
        addr       = 2'd0;
        valid_reg  = 1'b0;
        repeat (2) @(posedge clk_ula);
        do_reset();
        mon_en = 1'b1;
        @(negedge clk_ula);
        chk("rst_C", 32'(C), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);

        // Basic ADD, followed by a quiet cycle.
        wr(2'd1, 16'h0003);
        op(2'd0, 16'h0005, 2'd1);
        idle(1);

        // Wrap-around and borrow.
        wr(2'd2, 16'h0001);
        op(2'd0, 16'hFFFF, 2'd2);
        op(2'd1, 16'h0000, 2'd2);

        // Same-edge write is not bypassed into the operand.
        wr(2'd0, 16'h00F0);
        cycle(1'b1, 2'd2, 16'h0FF0, 2'd0, 1'b1, 2'd0, 16'h0F00);
        op(2'd2, 16'h0FF0, 2'd0);

        // MUL with a dropped ADD and a register write while busy.
        wr(2'd3, 16'h0100);
        op(2'd3, 16'h0300, 2'd3);
        idle(4);
        op(2'd0, 16'h1234, 2'd1);
        wr(2'd3, 16'hABCD);
        idle(13);
        wr(2'd3, 16'h0009);
        op(2'd3, 16'h0007, 2'd3);
        idle(17);

        // Reset in the middle of a multiply.
        op(2'd3, 16'h0123, 2'd3);
        idle(6);
        do_reset();
        idle(20);
        for (int i = 0; i < 4; i++) op(2'd0, 16'h0000, 2'(i));

        // Four single-cycle ops back to back.
        wr(2'd1, 16'h8001);
        wr(2'd2, 16'h00FF);
        op(2'd0, 16'h8000, 2'd1);
        op(2'd1, 16'h0010, 2'd2);
        op(2'd2, 16'hF0F0, 2'd1);
        op(2'd0, 16'h7FFF, 2'd1);
        idle(2);

        // Random traffic, including occasional resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                      16'($urandom()), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
                      16'($urandom()));
            end
        end
        idle(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ula_core.md
Name: ula_core

Overview:
- Responder end of the ULA stimulus interface. Consumes the operand/opcode stream and the register-write stream that the bench driver produces.
- Contains a 4-entry register bank, written through data_in/addr/valid_reg.
- ALU computes A op REG[reg_sel] and returns a registered result with a valid pulse; this is what the output monitor observes.
- MUL is iterative (shift-add) and multi-cycle, with a busy indication; all other ops complete in a single cycle.

Parameters:
- DATA_W, 16, operand/result/register width.
- NREGS, 4, register bank depth (select/address width = clog2(NREGS) = 2).

Ports:
- clk_ula  input  1  single clock.
- rst  input  1  reset, synchronous, active-high.
- A  input  DATA_W  operand A.
- reg_sel  input  2  selects operand B = REG[reg_sel].
- instru  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 MUL.
- valid_ula  input  1  op request qualifier.
- data_in  input  DATA_W  register write data.
- addr  input  2  register write address.
- valid_reg  input  1  register write qualifier.
- C  output  DATA_W  result (registered).
- carry  output  1  ADD carry-out / SUB borrow / MUL high-half-nonzero; 0 for AND.
- valid_out  output  1  one-cycle pulse: C/carry valid.
- busy  output  1  MUL in progress; new ops not accepted.
- drop  output  1  one-cycle pulse: valid_ula arrived while busy; op discarded.

Behaviour:
- Single clock domain. Reset is synchronous, active-high: rst sampled high at a clk_ula rising edge resets the block.

Reset values:
- REG[0..3] = 0, C = 0, carry = 0, valid_out = 0, busy = 0, drop = 0.
- MUL state machine returns to IDLE.
- rst dominates all other inputs in the same cycle.

Register write:
- valid_reg high at an edge -> REG[addr] <= data_in. Always accepted, including while busy.
- No write is lost.

Operand read:
- B = REG[reg_sel] is sampled at the accept edge.
- Same-edge write to the same index: the operand uses the OLD value (no bypass). The new value is visible from the next op onward.

Accept:
- An op is accepted at an edge where valid_ula = 1 and busy = 0.
- valid_ula = 1 with busy = 1 -> op discarded; drop = 1 for the following cycle; no other effect.

ADD / SUB / AND:
- Latency 1: C, carry and valid_out = 1 appear after the accept edge.
- valid_out is 0 in every cycle without a new completion. C and carry hold their last value.
- ADD: C = (A + B) mod 2^DATA_W; carry = bit DATA_W of the sum.
- SUB: C = (A - B) mod 2^DATA_W; carry = 1 iff A < B (unsigned).
- AND: C = A & B; carry = 0.

MUL state machine (IDLE -> MUL -> IDLE):
- Accept with instru = 11: capture A and B, clear a 2*DATA_W accumulator, load counter = DATA_W, busy = 1. Next state MUL.
- MUL state: one shift-add step per cycle, counter decrements.
- Completion: at the DATA_W-th edge after accept, C = low DATA_W bits of the product, carry = |(high DATA_W bits), valid_out = 1, busy = 0. Next state IDLE.
- busy is high for exactly DATA_W cycles (16).
- A new op may be accepted in the first cycle busy is low, i.e. the cycle in which valid_out is high.
- Register writes during MUL do not affect the captured operands.

Other rules:
- Back-to-back single-cycle ops: one accept per cycle, valid_out high on consecutive cycles.
- rst during MUL: the op is aborted, no valid_out, busy = 0 on the following cycle.
- The outputs have no backpressure; the consumer must sample on valid_out.

Test Plan:
- Reset, then write REG[1] = 0x0003; op A = 0x0005, reg_sel = 1, ADD -> next cycle valid_out = 1, C = 0x0008, carry = 0; the cycle after, valid_out = 0.
- REG[2] = 0x0001; ADD with A = 0xFFFF -> C = 0x0000, carry = 1. SUB with A = 0x0000 -> C = 0xFFFF, carry = 1.
- REG[0] = 0x00F0; same-edge write REG[0] = 0x0F00 and op AND, A = 0x0FF0, reg_sel = 0 -> C = 0x00F0 (old value). Next AND with the same A -> C = 0x0F00.
- REG[3] = 0x0100; MUL with A = 0x0300, reg_sel = 3:
  - busy = 1 for 16 cycles.
  - ADD issued in cycle 5 -> drop pulses, no valid_out.
  - Completion -> C = 0x0000, carry = 1 (product 0x30000).
  - Repeat with A = 0x0007, REG[3] = 0x0009 -> C = 0x003F, carry = 0.
- MUL started, rst asserted in cycle 8 -> no valid_out ever; all REG = 0, busy = 0.
- Four consecutive ADD/SUB/AND ops on consecutive cycles -> four consecutive valid_out cycles with matching C values, in order.
